// File: rtl/lowpower_bus_decoder.sv
// rtl/lowpower_bus_decoder.sv - multi-scheme low-power bus decoder
// Recovers the payload word from a normal, bus-invert, transition, gray or T0 encoded bus.
module lowpower_bus_decoder #(
  parameter int WIDTH  = 8,
  parameter int STRIDE = 1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             vld_in,
  input  logic [WIDTH:0]   B,
  output logic [WIDTH-1:0] A,
  output logic             vld_out,
  output logic             err
);

  localparam logic [2:0] MODE_NORMAL = 3'd0;
  localparam logic [2:0] MODE_BINV   = 3'd1;
  localparam logic [2:0] MODE_TRANS  = 3'd2;
  localparam logic [2:0] MODE_GRAY   = 3'd3;
  localparam logic [2:0] MODE_T0     = 3'd4;
  localparam logic [WIDTH-1:0] STRIDE_W = WIDTH'(STRIDE);

  logic [WIDTH-1:0] d;
  logic             side;
  logic [2:0]       mode_q;
  logic [WIDTH-1:0] prev_bus;
  logic [WIDTH-1:0] prev_addr;
  logic             mode_change;
  logic [WIDTH-1:0] hist_bus;
  logic [WIDTH-1:0] hist_addr;
  logic [WIDTH-1:0] gray_dec;
  logic [WIDTH-1:0] dec;
  logic             reserved;

  assign d    = B[WIDTH-1:0];
  assign side = B[WIDTH];

  // A mode switch behaves like a freshly reset encoder, even for a word on that same edge.
  assign mode_change = (mode != mode_q);
  assign hist_bus    = mode_change ? '0 : prev_bus;
  assign hist_addr   = mode_change ? '0 : prev_addr;
  assign reserved    = (mode > MODE_T0);

  always_comb begin
    gray_dec = '0;
    gray_dec[WIDTH-1] = d[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      gray_dec[i] = gray_dec[i+1] ^ d[i];
    end
  end

  always_comb begin
    dec = d;
    case (mode)
      MODE_NORMAL: dec = d;
      MODE_BINV:   dec = side ? ~d : d;
      MODE_TRANS:  dec = d ^ hist_bus;
      MODE_GRAY:   dec = gray_dec;
      MODE_T0:     dec = side ? hist_addr + STRIDE_W : d;
      default:     dec = d;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      A         <= '0;
      vld_out   <= 1'b0;
      err       <= 1'b0;
      prev_bus  <= '0;
      prev_addr <= '0;
      mode_q    <= '0;
    end else begin
      mode_q  <= mode;
      vld_out <= vld_in;
      if (vld_in) begin
        A <= dec;
      end
      if (vld_in && reserved) begin
        err <= 1'b1;
      end
      if (vld_in && mode == MODE_TRANS) begin
        prev_bus <= d;
      end else if (mode_change) begin
        prev_bus <= '0;
      end
      if (vld_in && mode == MODE_T0) begin
        prev_addr <= dec;
      end else if (mode_change) begin
        prev_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lowpower_bus_decoder.sv
// tb/tb_lowpower_bus_decoder.sv - directed vector bench for lowpower_bus_decoder
module tb_lowpower_bus_decoder;

  logic       ck;
  logic       rst;
  logic [2:0] mode;
  logic       vld_in;
  logic [8:0] B;
  logic [7:0] A;
  logic       vld_out;
  logic       err;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [2:0] mode;
    logic       vld;
    logic [8:0] bus;
    logic [7:0] exp_a;
    logic       exp_vld;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  lowpower_bus_decoder #(.WIDTH(8), .STRIDE(1)) dut (
    .ck(ck),
    .rst(rst),
    .mode(mode),
    .vld_in(vld_in),
    .B(B),
    .A(A),
    .vld_out(vld_out),
    .err(err)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] m, input logic v, input logic [8:0] b,
                     input logic [7:0] ea, input logic ev, input logic ee);
    vec_t r;
    r.mode = m; r.vld = v; r.bus = b;
    r.exp_a = ea; r.exp_vld = ev; r.exp_err = ee;
    vecs.push_back(r);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    mode = 3'd0;
    vld_in = 1'b0;
    B = '0;

    // normal and bus-invert
    add(3'd0, 1, 9'h03C, 8'h3C, 1, 0);
    add(3'd1, 1, 9'h10F, 8'hF0, 1, 0);
    add(3'd1, 1, 9'h00F, 8'h0F, 1, 0);
    add(3'd1, 0, 9'h1FF, 8'h0F, 0, 0);
    // transition, idle cycles must not disturb prev_bus
    add(3'd2, 1, 9'h055, 8'h55, 1, 0);
    add(3'd2, 1, 9'h000, 8'h55, 1, 0);
    add(3'd2, 1, 9'h0FF, 8'hFF, 1, 0);
    add(3'd2, 0, 9'h012, 8'hFF, 0, 0);
    add(3'd2, 0, 9'h012, 8'hFF, 0, 0);
    add(3'd2, 0, 9'h012, 8'hFF, 0, 0);
    add(3'd2, 1, 9'h00F, 8'hF0, 1, 0);
    // gray
    add(3'd3, 1, 9'h0C0, 8'h80, 1, 0);
    add(3'd3, 1, 9'h001, 8'h01, 1, 0);
    add(3'd3, 1, 9'h0FF, 8'hAA, 1, 0);
    // T0 including wrap
    add(3'd4, 1, 9'h03F, 8'h3F, 1, 0);
    add(3'd4, 1, 9'h1AA, 8'h40, 1, 0);
    add(3'd4, 1, 9'h1AA, 8'h41, 1, 0);
    add(3'd4, 1, 9'h0FF, 8'hFF, 1, 0);
    add(3'd4, 1, 9'h100, 8'h00, 1, 0);
    add(3'd4, 1, 9'h041, 8'h41, 1, 0);
    // mode switches clear history on the switching edge
    add(3'd2, 1, 9'h033, 8'h33, 1, 0);
    add(3'd4, 1, 9'h100, 8'h01, 1, 0);
    // reserved mode sets sticky err
    add(3'd6, 1, 9'h05A, 8'h5A, 1, 1);
    add(3'd0, 0, 9'h000, 8'h5A, 0, 1);
    add(3'd0, 1, 9'h077, 8'h77, 1, 1);

    #12;
    check("reset_a", A, 8'h00);
    check("reset_vld", {7'd0, vld_out}, 8'h00);
    check("reset_err", {7'd0, err}, 8'h00);
    @(negedge ck);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      mode   = vecs[i].mode;
      vld_in = vecs[i].vld;
      B      = vecs[i].bus;
      @(posedge ck);
      #1;
      check($sformatf("v%0d_a", i), A, vecs[i].exp_a);
      check($sformatf("v%0d_vld", i), {7'd0, vld_out}, {7'd0, vecs[i].exp_vld});
      check($sformatf("v%0d_err", i), {7'd0, err}, {7'd0, vecs[i].exp_err});
    end

    // asynchronous reset mid-stream, observed before the next edge
    mode = 3'd0; vld_in = 1'b1; B = 9'h099;
    @(posedge ck);
    #1;
    check("pre_rst_a", A, 8'h99);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_a", A, 8'h00);
    check("async_rst_vld", {7'd0, vld_out}, 8'h00);
    check("async_rst_err", {7'd0, err}, 8'h00);
    @(negedge ck);
    rst = 1'b0;
    vld_in = 1'b0;
    @(posedge ck);
    #1;
    check("post_rst_idle_vld", {7'd0, vld_out}, 8'h00);
    check("post_rst_idle_a", A, 8'h00);

    // history after reset: T0 increment starts from 0
    mode = 3'd4; vld_in = 1'b1; B = 9'h100;
    @(posedge ck);
    #1;
    check("post_rst_t0_a", A, 8'h01);
    check("post_rst_t0_vld", {7'd0, vld_out}, 8'h01);
    vld_in = 1'b0;
    @(posedge ck);
    #1;
    check("single_cycle_vld", {7'd0, vld_out}, 8'h00);
    check("hold_a", A, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
